// File: rtl/usb_msg_responder.sv
// Command-triggered message transmitter between usb_uart byte pipes and user logic.
// A received trigger byte selects a stored message that is streamed back out, one byte per handshake.
module usb_msg_responder #(
   parameter int         MSG_COUNT   = 4,
   parameter int         MSG_MAX_LEN = 16,
   parameter logic [7:0] TRIG_BASE   = 8'h61,
   localparam int        MSG_W       = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
   localparam int        ADDR_W      = $clog2(MSG_MAX_LEN)
) (
   input  logic              clk_48mhz,
   input  logic              reset,
   input  logic [7:0]        uart_out_data,
   input  logic              uart_out_valid,
   output logic              uart_out_ready,
   output logic [7:0]        uart_in_data,
   output logic              uart_in_valid,
   input  logic              uart_in_ready,
   input  logic              cfg_wr_en,
   input  logic              cfg_len_wr_en,
   input  logic [MSG_W-1:0]  cfg_wr_msg,
   input  logic [ADDR_W-1:0] cfg_wr_addr,
   input  logic [7:0]        cfg_wr_data,
   input  logic [ADDR_W:0]   cfg_len_data,
   output logic              busy,
   output logic [MSG_W-1:0]  active_msg,
   output logic [7:0]        drop_count
);

   typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MSG_MAX_LEN);

   logic [7:0]        mem [MSG_COUNT][MSG_MAX_LEN];
   logic [ADDR_W:0]   len_q [MSG_COUNT];

   state_t            state_q, state_d;
   logic [MSG_W-1:0]  cur_q, cur_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   cur_len_q, cur_len_d;
   logic              pend_q, pend_d;
   logic [MSG_W-1:0]  pend_msg_q, pend_msg_d;
   logic [7:0]        drop_q, drop_d;
   logic [7:0]        data_q, data_d;
   logic              ready_q;

   logic [7:0]        trig_off;
   logic              trig_hit;
   logic [MSG_W-1:0]  trig_msg;
   logic              hs;
   logic              last;
   logic              launch;
   logic [MSG_W-1:0]  launch_msg;

   // Byte storage is deliberately left without reset.
   always_ff @(posedge clk_48mhz) begin
      if (cfg_wr_en && state_q == ST_IDLE && int'(cfg_wr_msg) < MSG_COUNT) begin
         mem[cfg_wr_msg][cfg_wr_addr] <= cfg_wr_data;
      end
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         for (int k = 0; k < MSG_COUNT; k++) begin
            len_q[k] <= '0;
         end
      end else if (cfg_len_wr_en && state_q == ST_IDLE && int'(cfg_wr_msg) < MSG_COUNT) begin
         len_q[cfg_wr_msg] <= (cfg_len_data > MAX_LEN) ? MAX_LEN : cfg_len_data;
      end
   end

   // A trigger only counts for a slot that currently has a non-zero length.
   always_comb begin
      trig_off = uart_out_data - TRIG_BASE;
      trig_hit = 1'b0;
      trig_msg = '0;
      for (int k = 0; k < MSG_COUNT; k++) begin
         if (uart_out_valid && ready_q && trig_off == 8'(k) && len_q[k] != '0) begin
            trig_hit = 1'b1;
            trig_msg = MSG_W'(k);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      idx_d      = idx_q;
      cur_len_d  = cur_len_q;
      pend_d     = pend_q;
      pend_msg_d = pend_msg_q;
      drop_d     = drop_q;
      data_d     = data_q;
      launch     = 1'b0;
      launch_msg = trig_msg;
      hs         = (state_q == ST_SEND) && uart_in_ready;
      last       = hs && (({1'b0, idx_q} + 1'b1) == cur_len_q);

      case (state_q)
         ST_IDLE: begin
            if (trig_hit) begin
               launch = 1'b1;
            end
         end
         ST_SEND: begin
            if (last) begin
               // The pending slot goes first; a same-cycle trigger takes its place.
               if (pend_q) begin
                  launch     = 1'b1;
                  launch_msg = pend_msg_q;
                  pend_d     = trig_hit;
                  pend_msg_d = trig_msg;
               end else if (trig_hit) begin
                  launch = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (hs) begin
                  idx_d  = idx_q + 1'b1;
                  data_d = mem[cur_q][idx_q + 1'b1];
               end
               if (trig_hit) begin
                  if (!pend_q) begin
                     pend_d     = 1'b1;
                     pend_msg_d = trig_msg;
                  end else if (drop_q != 8'hFF) begin
                     drop_d = drop_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
         state_d   = ST_SEND;
         cur_d     = launch_msg;
         idx_d     = '0;
         cur_len_d = len_q[launch_msg];
         data_d    = mem[launch_msg][0];
      end
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_q      <= '0;
         idx_q      <= '0;
         cur_len_q  <= '0;
         pend_q     <= 1'b0;
         pend_msg_q <= '0;
         drop_q     <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         idx_q      <= idx_d;
         cur_len_q  <= cur_len_d;
         pend_q     <= pend_d;
         pend_msg_q <= pend_msg_d;
         drop_q     <= drop_d;
         data_q     <= data_d;
         ready_q    <= 1'b1;
      end
   end

   assign uart_out_ready = ready_q;
   assign uart_in_valid  = (state_q == ST_SEND);
   assign uart_in_data   = data_q;
   assign busy           = (state_q == ST_SEND);
   assign active_msg     = cur_q;
   assign drop_count     = drop_q;

endmodule

// File: tb/tb_usb_msg_responder.sv
// Bench for usb_msg_responder: directed scenarios plus random traffic, all checked every cycle
// against a queue-based model of the message stream.
module tb_usb_msg_responder;

   logic       clk_48mhz = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] uart_out_data = '0;
   logic       uart_out_valid = 1'b0;
   logic       uart_out_ready;
   logic [7:0] uart_in_data;
   logic       uart_in_valid;
   logic       uart_in_ready = 1'b1;
   logic       cfg_wr_en = 1'b0;
   logic       cfg_len_wr_en = 1'b0;
   logic [1:0] cfg_wr_msg = '0;
   logic [3:0] cfg_wr_addr = '0;
   logic [7:0] cfg_wr_data = '0;
   logic [4:0] cfg_len_data = '0;
   logic       busy;
   logic [1:0] active_msg;
   logic [7:0] drop_count;

   usb_msg_responder #(.MSG_COUNT(4), .MSG_MAX_LEN(16), .TRIG_BASE(8'h61)) dut (
      .clk_48mhz(clk_48mhz), .reset(reset),
      .uart_out_data(uart_out_data), .uart_out_valid(uart_out_valid), .uart_out_ready(uart_out_ready),
      .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready),
      .cfg_wr_en(cfg_wr_en), .cfg_len_wr_en(cfg_len_wr_en), .cfg_wr_msg(cfg_wr_msg),
      .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_len_data(cfg_len_data),
      .busy(busy), .active_msg(active_msg), .drop_count(drop_count)
   );

   // clock / reset
   always #10 clk_48mhz = ~clk_48mhz;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int rdy_mode = 0;   // 0 high, 1 toggle, 2 random, 3 low

   always @(posedge clk_48mhz) cyc++;

   always @(posedge clk_48mhz) begin
      #1;
      case (rdy_mode)
         0: uart_in_ready = 1'b1;
         1: uart_in_ready = ~uart_in_ready;
         2: uart_in_ready = ($urandom_range(0, 3) != 0);
         default: uart_in_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // behavioural model: the outgoing stream is a queue of bytes still owed
   logic [7:0] slot_data [4][16];
   logic [7:0] m_mem [4][16];
   int         m_len [4];
   logic [7:0] exp_q [$];
   int         m_active = 0;
   int         m_pend = -1;
   int         m_drop = 0;
   bit         m_rdy = 1'b0;

   task automatic launch(input int s);
      m_active = s;
      for (int i = 0; i < m_len[s]; i++) exp_q.push_back(m_mem[s][i]);
   endtask

   always @(posedge clk_48mhz) begin : model_blk
      bit was_busy;
      bit tr;
      bit hs;
      logic [7:0] off;
      int t;
      was_busy = (exp_q.size() != 0);
      if (reset) begin
         exp_q.delete();
         m_pend = -1;
         m_drop = 0;
         m_active = 0;
         m_rdy = 1'b0;
         for (int k = 0; k < 4; k++) m_len[k] = 0;
      end else begin
         off = uart_out_data - 8'h61;
         t = int'(off);
         tr = uart_out_valid && m_rdy && (off < 8'd4) && (m_len[off[1:0]] != 0);
         hs = was_busy && uart_in_ready;
         if (hs) void'(exp_q.pop_front());
         if (hs && exp_q.size() == 0) begin
            if (m_pend >= 0) begin
               launch(m_pend);
               m_pend = tr ? t : -1;
            end else if (tr) begin
               launch(t);
            end
         end else if (tr) begin
            if (!was_busy) launch(t);
            else if (m_pend < 0) m_pend = t;
            else if (m_drop < 255) m_drop++;
         end
         if (!was_busy) begin
            if (cfg_wr_en) m_mem[cfg_wr_msg][cfg_wr_addr] = cfg_wr_data;
            if (cfg_len_wr_en) m_len[cfg_wr_msg] = (cfg_len_data > 5'd16) ? 16 : int'(cfg_len_data);
         end
         m_rdy = 1'b1;
      end
   end

   // per-cycle compare
   always @(negedge clk_48mhz) begin
      if (chk_en) begin
         check("uart_in_valid", uart_in_valid, exp_q.size() != 0);
         check("busy", busy, exp_q.size() != 0);
         if (exp_q.size() != 0) check("uart_in_data", uart_in_data, exp_q[0]);
         check("drop_count", drop_count, m_drop);
         check("active_msg", active_msg, m_active);
         check("uart_out_ready", uart_out_ready, m_rdy);
      end
   end

   // handshake log for literal order/timing checks
   logic [7:0] hs_log [$];
   int         hs_cyc [$];
   always @(negedge clk_48mhz) begin
      if (chk_en && !reset && uart_in_valid === 1'b1 && uart_in_ready) begin
         hs_log.push_back(uart_in_data);
         hs_cyc.push_back(cyc);
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk_48mhz);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      uart_out_valid = 1'b1;
      uart_out_data = b;
      step();
      uart_out_valid = 1'b0;
   endtask

   task automatic cfg_byte(input int s, input int a, input logic [7:0] d);
      cfg_wr_en = 1'b1;
      cfg_wr_msg = 2'(s);
      cfg_wr_addr = 4'(a);
      cfg_wr_data = d;
      step();
      cfg_wr_en = 1'b0;
   endtask

   task automatic cfg_len(input int s, input int l);
      cfg_len_wr_en = 1'b1;
      cfg_wr_msg = 2'(s);
      cfg_len_data = 5'(l);
      step();
      cfg_len_wr_en = 1'b0;
   endtask

   task automatic config_all();
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 16; i++) cfg_byte(s, i, slot_data[s][i]);
      cfg_len(0, 14);
      cfg_len(1, 4);
      cfg_len(2, 2);
      cfg_len(3, 31);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      check("idle_reached", busy, 1'b0);
   endtask

   task automatic clear_log();
      hs_log.delete();
      hs_cyc.delete();
   endtask

   task automatic compare_log(input string name, input string exp);
      int n;
      check({name, "_count"}, hs_log.size(), exp.len());
      n = (hs_log.size() < exp.len()) ? hs_log.size() : exp.len();
      for (int i = 0; i < n; i++) check({name, "_byte"}, hs_log[i], exp[i]);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      string s0, s1, s2;
      s0 = "Hello World!\r\n";
      s1 = "BYE!";
      s2 = "c2";
      for (int i = 0; i < 16; i++) begin
         slot_data[0][i] = (i < s0.len()) ? s0[i] : 8'h2e;
         slot_data[1][i] = (i < s1.len()) ? s1[i] : 8'h2e;
         slot_data[2][i] = (i < s2.len()) ? s2[i] : 8'h2e;
         slot_data[3][i] = 8'($urandom);
      end
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 16; i++) m_mem[s][i] = '0;

      repeat (3) @(posedge clk_48mhz);
      #1;
      chk_en = 1'b1;
      check("rst_valid", uart_in_valid, 1'b0);
      check("rst_data", uart_in_data, 8'h00);
      check("rst_out_ready", uart_out_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_drop", drop_count, 8'd0);
      check("rst_active", active_msg, 2'd0);
      reset = 1'b0;
      step();
      check("ready_after_reset", uart_out_ready, 1'b1);

      // trigger with all lengths zero is ignored
      pulse_rx("a");
      step();
      check("unconfigured_busy", busy, 1'b0);

      config_all();

      // plain send, ready held high
      clear_log();
      check("t1_valid_before", uart_in_valid, 1'b0);
      pulse_rx("a");
      check("t1_first_valid", uart_in_valid, 1'b1);
      check("t1_first_byte", uart_in_data, 8'h48);
      wait_idle(200);
      compare_log("t1", "Hello World!\r\n");
      if (hs_cyc.size() == 14) check("t1_back_to_back", hs_cyc[13] - hs_cyc[0], 13);

      // ready toggling
      rdy_mode = 1;
      clear_log();
      pulse_rx("a");
      wait_idle(200);
      compare_log("t2", "Hello World!\r\n");
      rdy_mode = 0;

      // queued trigger plus two drops
      do_reset();
      config_all();
      clear_log();
      pulse_rx("a");
      rdy_mode = 3;
      step();
      pulse_rx("b");
      pulse_rx("c");
      pulse_rx("d");
      rdy_mode = 0;
      wait_idle(400);
      check("t3_drop", drop_count, 8'd2);
      compare_log("t3", "Hello World!\r\nBYE!");
      if (hs_cyc.size() >= 15) check("t3_no_gap", hs_cyc[14] - hs_cyc[13], 1);

      // non-triggers and disabled slot
      pulse_rx("e");
      pulse_rx(8'h60);
      repeat (3) step();
      check("t4_busy", busy, 1'b0);
      check("t4_drop", drop_count, 8'd2);
      cfg_len(0, 0);
      pulse_rx("a");
      repeat (3) step();
      check("t4_len0_busy", busy, 1'b0);
      check("t4_log_unchanged", hs_log.size(), 18);
      check("t4_drop_unchanged", drop_count, 8'd2);
      cfg_len(0, 14);

      // trigger in the cycle of the last handshake
      clear_log();
      pulse_rx("a");
      repeat (13) step();
      pulse_rx("b");
      check("t5_valid", uart_in_valid, 1'b1);
      check("t5_byte0", uart_in_data, 8'h42);
      check("t5_active", active_msg, 2'd1);
      wait_idle(200);
      compare_log("t5", "Hello World!\r\nBYE!");
      if (hs_cyc.size() >= 15) check("t5_no_gap", hs_cyc[14] - hs_cyc[13], 1);

      // reset mid-message
      clear_log();
      pulse_rx("a");
      repeat (5) step();
      reset = 1'b1;
      step();
      check("t6_valid_after_reset", uart_in_valid, 1'b0);
      reset = 1'b0;
      step();
      step();
      pulse_rx("a");
      repeat (3) step();
      check("t6_busy", busy, 1'b0);
      check("t6_log", hs_log.size(), 5);

      // drop counter saturation
      config_all();
      rdy_mode = 3;
      step();
      pulse_rx("a");
      for (int i = 0; i < 260; i++) pulse_rx("b");
      check("t7_drop_sat", drop_count, 8'd255);
      rdy_mode = 0;
      wait_idle(200);

      // random traffic
      do_reset();
      config_all();
      rdy_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         uart_out_valid = ($urandom_range(0, 3) == 0);
         uart_out_data = ($urandom_range(0, 9) < 7) ? 8'(8'h5f + $urandom_range(0, 7)) : 8'($urandom);
         if (!uart_out_valid && $urandom_range(0, 31) == 0) begin
            cfg_wr_msg = 2'($urandom_range(0, 3));
            cfg_wr_addr = 4'($urandom_range(0, 15));
            cfg_wr_data = 8'($urandom);
            cfg_len_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) cfg_wr_en = 1'b1;
            else cfg_len_wr_en = 1'b1;
         end
         step();
         cfg_wr_en = 1'b0;
         cfg_len_wr_en = 1'b0;
      end
      uart_out_valid = 1'b0;
      rdy_mode = 0;
      wait_idle(500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
